// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Load-side responder for the data RAM. Accepts byte/half/word
//               loads, issues a synchronous word read, merges a same-cycle
//               store to the same word, extracts and extends the addressed
//               lane, and returns the result through a valid/ready handshake
//               backed by a one-entry hold buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit #(
    parameter  int ADDR_WORDS = 2048,
    localparam int IW         = $clog2(ADDR_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    // Load request from the MEM stage
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_signed_i,
    // Data RAM read port
    output logic          mem_rd_en_o,
    output logic [IW-1:0] mem_rd_addr_o,
    input  logic [31:0]   mem_rd_data_i,
    // Store commit snoop
    input  logic          st_en_i,
    input  logic [IW-1:0] st_word_i,
    input  logic [3:0]    st_be_i,
    input  logic [31:0]   st_data_i,
    // Load response
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [31:0]   resp_data_o,
    output logic          resp_err_o
);

    localparam logic [1:0]  SIZE_BYTE  = 2'b01;
    localparam logic [1:0]  SIZE_HALF  = 2'b10;
    localparam logic [1:0]  SIZE_WORD  = 2'b11;
    localparam logic [31:0] WORD_LIMIT = 32'(ADDR_WORDS);

    // S1 stage: one cycle behind the accepted request, aligned with RAM data
    logic          s1_valid_q, s1_valid_d;
    logic          s1_err_q,   s1_err_d;
    logic [1:0]    s1_size_q,  s1_size_d;
    logic          s1_signed_q, s1_signed_d;
    logic [1:0]    s1_lane_q,  s1_lane_d;
    logic          s1_byp_q,   s1_byp_d;
    logic [3:0]    s1_be_q,    s1_be_d;
    logic [31:0]   s1_sdata_q, s1_sdata_d;

    // Hold buffer: parks a formatted result while the consumer stalls
    logic          hold_valid_q, hold_valid_d;
    logic [31:0]   hold_data_q,  hold_data_d;
    logic          hold_err_q,   hold_err_d;

    logic [IW-1:0] req_word;
    logic          req_err;
    logic          accept;
    logic [31:0]   merged_word;
    logic [31:0]   fmt_data;
    logic          capture;

    assign req_word = req_addr_i[IW+1:2];

    // Classify the incoming request: illegal size, misalignment or range
    always_comb begin
        req_err = 1'b0;
        if (req_size_i == 2'b00)
            req_err = 1'b1;
        if (req_size_i == SIZE_HALF && req_addr_i[0])
            req_err = 1'b1;
        if (req_size_i == SIZE_WORD && req_addr_i[1:0] != 2'b00)
            req_err = 1'b1;
        if ({2'b00, req_addr_i[31:2]} >= WORD_LIMIT)
            req_err = 1'b1;
    end

    // A pending S1 result that cannot leave this cycle blocks new requests,
    // as does a full hold buffer; S1 and hold are therefore never both full.
    assign req_ready_o   = !reset && !hold_valid_q && !(s1_valid_q && !resp_ready_i);
    assign accept        = req_valid_i && req_ready_o;
    assign mem_rd_en_o   = accept && !req_err;
    assign mem_rd_addr_o = req_word;

    // RAM data reflects the word before the store at that edge, so overlay
    // the bytes the same-cycle store wrote, then extract and extend the lane
    always_comb begin
        merged_word = mem_rd_data_i;
        for (int i = 0; i < 4; i++) begin
            if (s1_byp_q && s1_be_q[i])
                merged_word[8*i +: 8] = s1_sdata_q[8*i +: 8];
        end
        fmt_data = 32'h0;
        case (s1_size_q)
            SIZE_BYTE: fmt_data = {{24{s1_signed_q && merged_word[8*s1_lane_q + 7]}},
                                   merged_word[8*s1_lane_q +: 8]};
            SIZE_HALF: fmt_data = {{16{s1_signed_q && merged_word[16*s1_lane_q[1] + 15]}},
                                   merged_word[16*s1_lane_q[1] +: 16]};
            SIZE_WORD: fmt_data = merged_word;
            default:   fmt_data = 32'h0;
        endcase
        if (s1_err_q)
            fmt_data = 32'h0;
    end

    // Next-state for S1 and hold; S1 always empties unless refilled, since
    // its result either goes to the consumer or into hold this cycle
    always_comb begin
        capture      = s1_valid_q && !hold_valid_q && !resp_ready_i;
        s1_valid_d   = accept;
        s1_err_d     = req_err;
        s1_size_d    = req_size_i;
        s1_signed_d  = req_signed_i;
        s1_lane_d    = req_addr_i[1:0];
        s1_byp_d     = st_en_i && (st_word_i == req_word) && !req_err;
        s1_be_d      = st_be_i;
        s1_sdata_d   = st_data_i;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_err_d   = hold_err_q;
        if (capture) begin
            hold_valid_d = 1'b1;
            hold_data_d  = fmt_data;
            hold_err_d   = s1_err_q;
        end else if (hold_valid_q && resp_ready_i) begin
            hold_valid_d = 1'b0;
        end
    end

    // Pipeline and hold registers; reset discards any in-flight result
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_size_q    <= 2'b00;
            s1_signed_q  <= 1'b0;
            s1_lane_q    <= 2'b00;
            s1_byp_q     <= 1'b0;
            s1_be_q      <= 4'h0;
            s1_sdata_q   <= 32'h0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 32'h0;
            hold_err_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_err_q     <= s1_err_d;
            s1_size_q    <= s1_size_d;
            s1_signed_q  <= s1_signed_d;
            s1_lane_q    <= s1_lane_d;
            s1_byp_q     <= s1_byp_d;
            s1_be_q      <= s1_be_d;
            s1_sdata_q   <= s1_sdata_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_err_q   <= hold_err_d;
        end
    end

    // Response mux: hold has priority; everything reads as zero in reset
    always_comb begin
        resp_valid_o = 1'b0;
        resp_data_o  = 32'h0;
        resp_err_o   = 1'b0;
        if (!reset) begin
            if (hold_valid_q) begin
                resp_valid_o = 1'b1;
                resp_data_o  = hold_data_q;
                resp_err_o   = hold_err_q;
            end else if (s1_valid_q) begin
                resp_valid_o = 1'b1;
                resp_data_o  = fmt_data;
                resp_err_o   = s1_err_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Scoreboard bench for load_unit with a behavioural data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit;

    localparam int ADDR_WORDS = 2048;
    localparam int IW         = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = 32'h0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic          mem_rd_en;
    logic [IW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data = 32'h0;
    logic          st_en = 1'b0;
    logic [IW-1:0] st_word = '0;
    logic [3:0]    st_be = 4'h0;
    logic [31:0]   st_data = 32'h0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_data;
    logic          resp_err;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] exp_d_q[$];
    logic        exp_e_q[$];
    string       exp_n_q[$];

    logic [31:0] ram [0:ADDR_WORDS-1];

    load_unit #(.ADDR_WORDS(ADDR_WORDS)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_size_i    (req_size),
        .req_signed_i  (req_signed),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .st_en_i       (st_en),
        .st_word_i     (st_word),
        .st_be_i       (st_be),
        .st_data_i     (st_data),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .resp_err_o    (resp_err)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: the read returns the pre-write contents of the edge
    always @(posedge clock) begin
        if (mem_rd_en)
            mem_rd_data <= ram[mem_rd_addr];
        if (st_en) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b])
                    ram[st_word][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return {v[15:0] ^ 16'hC3A5, ~v[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random consumer stall pattern, only active in the random phase
    always @(negedge clock) begin
        if (rand_rdy)
            resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_err   = 1'b0;
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", {31'h0, resp_valid}, 32'h1);
                chk("stall_data", resp_data, prev_data);
                chk("stall_err", {31'h0, resp_err}, {31'h0, prev_err});
            end
            if (resp_valid && resp_ready) begin
                if (exp_d_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h err %b expected none", resp_data, resp_err);
                end else begin
                    string n;
                    n = exp_n_q.pop_front();
                    chk({n, "_data"}, resp_data, exp_d_q.pop_front());
                    chk({n, "_err"}, {31'h0, resp_err}, {31'h0, exp_e_q.pop_front()});
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
            prev_err   = resp_err;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Commit a store through the RAM store port for one cycle
    task automatic store(input int w, input logic [3:0] be, input logic [31:0] d);
        @(negedge clock);
        st_en = 1'b1; st_word = w[IW-1:0]; st_be = be; st_data = d;
        @(posedge clock);
        #1 st_en = 1'b0;
    endtask

    // Issue one load (optionally with a same-cycle store) and queue its result
    task automatic load(input string name, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] exp_d, input logic exp_e,
                        input logic se, input int sw, input logic [3:0] sb, input logic [31:0] sd);
        int n;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_signed = sg;
        st_en = se; st_word = sw[IW-1:0]; st_be = sb; st_data = sd;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: req_ready stuck at 0, expected 1 within 50 cycles", name);
        end else begin
            chk({name, "_rd_en"}, {31'h0, mem_rd_en}, {31'h0, !exp_e});
            if (!exp_e)
                chk({name, "_rd_addr"}, {21'h0, mem_rd_addr}, {21'h0, a[IW+1:2]});
            exp_d_q.push_back(exp_d);
            exp_e_q.push_back(exp_e);
            exp_n_q.push_back(name);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        st_en = 1'b0;
    endtask

    initial begin
        // Fill RAM through the store port while the DUT is held in reset
        @(negedge clock);
        req_valid = 1'b1;
        for (int i = 0; i < ADDR_WORDS; i++) begin
            st_en = 1'b1; st_word = i[IW-1:0]; st_be = 4'hF; st_data = pat(i);
            @(negedge clock);
            if (i == 3) begin
                #1;
                chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
                chk("rst_resp_data", resp_data, 32'h0);
                chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
                chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
            end
        end
        st_en = 1'b0;
        req_valid = 1'b0;
        reset = 1'b0;

        // Word load
        store(4, 4'hF, 32'hDEADBEEF);
        load("lw_10", 32'h10, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 4'h0, 32'h0);

        // Back-to-back byte loads, plus halves of the same word
        store(4, 4'hF, 32'h80123456);
        load("lb_13", 32'h13, 2'b01, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        load("lbu_13", 32'h13, 2'b01, 1'b0, 32'h00000080, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        load("lh_12", 32'h12, 2'b10, 1'b1, 32'hFFFF8012, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        load("lhu_10", 32'h10, 2'b10, 1'b0, 32'h00003456, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        load("lb_11", 32'h11, 2'b01, 1'b1, 32'h00000034, 1'b0, 1'b0, 0, 4'h0, 32'h0);

        // Error cases
        load("lh_21", 32'h21, 2'b10, 1'b1, 32'h0, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        load("lw_2000", 32'h2000, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        load("lw_22", 32'h22, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        load("size00", 32'h10, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        load("lw_1ffc", 32'h1FFC, 2'b11, 1'b0, pat(2047), 1'b0, 1'b0, 0, 4'h0, 32'h0);

        // Same-cycle store is merged; a store one cycle later is not
        store(8, 4'hF, 32'h11223344);
        load("byp_same", 32'h20, 2'b11, 1'b0, 32'h1122AA44, 1'b0, 1'b1, 8, 4'b0010, 32'h0000AA00);
        store(8, 4'hF, 32'h11223344);
        load("byp_late", 32'h20, 2'b11, 1'b0, 32'h11223344, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        store(8, 4'b0010, 32'h0000AA00);

        // Backpressure: three stalled cycles, then consume
        @(negedge clock);
        resp_ready = 1'b0;
        load("bp_lw", 32'h30, 2'b11, 1'b0, pat(12), 1'b0, 1'b0, 0, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        #1 chk("bp_ready_on_consume", {31'h0, req_ready}, 32'h0);
        @(negedge clock);
        #1 chk("bp_ready_after", {31'h0, req_ready}, 32'h1);

        // Reset in the cycle after accept discards the in-flight result
        load("rst_lw", 32'h40, 2'b11, 1'b0, pat(16), 1'b0, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        req_valid = 1'b1; req_addr = 32'h44; req_size = 2'b11;
        #1;
        chk("rst_mid_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h0);
        exp_d_q.delete();
        exp_e_q.delete();
        exp_n_q.delete();
        @(posedge clock);
        #1;
        chk("rst_after_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_after_data", resp_data, 32'h0);
        chk("rst_after_err", {31'h0, resp_err}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            #1 chk("post_rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end

        // Restore words touched above so random loads can use the pattern
        store(4, 4'hF, pat(4));
        store(8, 4'hF, pat(8));

        // Random word loads under random consumer stalls
        rand_rdy = 1'b1;
        for (int r = 0; r < 100; r++) begin
            int idx;
            idx = $urandom_range(0, ADDR_WORDS - 1);
            load("rnd", {idx[29:0], 2'b00}, 2'b11, 1'b0, pat(idx), 1'b0, 1'b0, 0, 4'h0, 32'h0);
        end
        @(negedge clock);
        rand_rdy = 1'b0;
        resp_ready = 1'b1;
        for (int w = 0; w < 20 && exp_d_q.size() != 0; w++)
            @(negedge clock);
        repeat (2) @(negedge clock);
        chk("drain_pending", exp_d_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
